multicycle_ctrl: RTL and testbench

Multicycle control unit that sequences the CPU datapath (instruction register, program counter, instruction memory, register file). It decodes the 16-bit instruction returned by the datapath and drives the per-cycle strobes: pc_ld, ir_ld, mem_en, mem_wrt, pc_branch and flush. It also drives the destination register address, the branch target and the ALU opcode. It sits beside the datapath in the CPU top level and owns all instruction timing.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_multicycle_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU function codes, control FSM states
// and the decoded-instruction record passed from ctrl_decode to the FSM.
package cpu_pkg;

  localparam logic [3:0] OPC_NOP = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_AND = 4'b0011;
  localparam logic [3:0] OPC_OR  = 4'b0100;
  localparam logic [3:0] OPC_XOR = 4'b0101;
  localparam logic [3:0] OPC_JMP = 4'b1000;
  localparam logic [3:0] OPC_BZ  = 4'b1001;
  localparam logic [3:0] OPC_LDI = 4'b1100;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic       is_alu;
    logic       is_ldi;
    logic       is_jmp;
    logic       is_bz;
    logic       is_hlt;
    logic       is_illegal;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; LDI and non-ALU opcodes report alu_op ADD.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OPC_NOP: ;
      OPC_ADD: begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OPC_SUB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OPC_AND: begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OPC_OR:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OPC_XOR: begin dec.is_alu = 1'b1; dec.alu_op = ALU_XOR; end
      OPC_JMP: dec.is_jmp = 1'b1;
      OPC_BZ:  dec.is_bz  = 1'b1;
      OPC_LDI: dec.is_ldi = 1'b1;
      OPC_HLT: dec.is_hlt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/WB sequencing with hold
// freeze; every output is decoded from the state register plus the IR.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [INST_W-1:0] inst,
  input  logic [DATA_W-1:0] regA,
  output logic              pc_ld,
  output logic              ir_ld,
  output logic              mem_en,
  output logic              mem_wrt,
  output logic              pc_branch,
  output logic              flush,
  output logic [3:0]        reg_out,
  output logic [ADDR_W-1:0] branch_addr,
  output logic [2:0]        alu_op,
  output logic              halted,
  output logic              illegal
);

  state_t state_reg, state_next;
  dec_t   dec;

  logic pc_ld_raw, ir_ld_raw, mem_wrt_raw, pc_branch_raw, flush_raw, illegal_raw;

  // The low nibble is an operand for the datapath only.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[3:0];

  ctrl_decode u_decode (
    .opcode (inst[15:12]),
    .dec    (dec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    pc_ld_raw     = 1'b0;
    ir_ld_raw     = 1'b0;
    mem_wrt_raw   = 1'b0;
    pc_branch_raw = 1'b0;
    flush_raw     = 1'b0;
    illegal_raw   = 1'b0;
    mem_en        = 1'b0;
    reg_out       = '0;
    branch_addr   = '0;
    alu_op        = ALU_ADD;
    halted        = 1'b0;

    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        ir_ld_raw  = 1'b1;
        pc_ld_raw  = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        illegal_raw = dec.is_illegal;
        if (dec.is_hlt)
          state_next = ST_HALT;
        else if (dec.is_alu || dec.is_ldi || dec.is_jmp || dec.is_bz)
          state_next = ST_EXEC;
        else
          state_next = ST_FETCH;
      end
      ST_EXEC: begin
        alu_op = dec.alu_op;
        if (dec.is_jmp || dec.is_bz)
          branch_addr = inst[4 +: ADDR_W];
        if (dec.is_jmp || (dec.is_bz && regA == '0)) begin
          pc_branch_raw = 1'b1;
          pc_ld_raw     = 1'b1;
          flush_raw     = 1'b1;
        end
        state_next = (dec.is_alu || dec.is_ldi) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        mem_en      = 1'b1;
        mem_wrt_raw = 1'b1;
        reg_out     = inst[11:8];
        alu_op      = dec.alu_op;
        state_next  = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_next = ST_IDLE;
    endcase

    // Freezing the state while masking strobes means each strobe fires once,
    // on the first unheld cycle of its state.
    if (hold) state_next = state_reg;
  end

  assign pc_ld     = pc_ld_raw     & ~hold;
  assign ir_ld     = ir_ld_raw     & ~hold;
  assign mem_wrt   = mem_wrt_raw   & ~hold;
  assign pc_branch = pc_branch_raw & ~hold;
  assign flush     = flush_raw     & ~hold;
  assign illegal   = illegal_raw   & ~hold;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected output vectors are queued as
// each cycle's stimulus is driven, then popped and compared mid-cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_ld, ir_ld, mem_en, mem_wrt, pc_branch, flush;
    logic [3:0] reg_out;
    logic [7:0] branch_addr;
    logic [2:0] alu_op;
    logic       halted, illegal;
  } out_t;

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_FETCH = 6'b110000;
  localparam logic [5:0] S_WB    = 6'b001100;
  localparam logic [5:0] S_WBH   = 6'b001000;
  localparam logic [5:0] S_BR    = 6'b100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] inst = '0;
  logic [7:0]  regA = '0;
  logic        pc_ld, ir_ld, mem_en, mem_wrt, pc_branch, flush, halted, illegal;
  logic [3:0]  reg_out;
  logic [7:0]  branch_addr;
  logic [2:0]  alu_op;

  out_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  multicycle_ctrl #(.DATA_W(8), .ADDR_W(8), .INST_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .inst        (inst),
    .regA        (regA),
    .pc_ld       (pc_ld),
    .ir_ld       (ir_ld),
    .mem_en      (mem_en),
    .mem_wrt     (mem_wrt),
    .pc_branch   (pc_branch),
    .flush       (flush),
    .reg_out     (reg_out),
    .branch_addr (branch_addr),
    .alu_op      (alu_op),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic [5:0] s, logic [3:0] r, logic [7:0] b,
                              logic [2:0] a, logic h, logic il);
    return {s, r, b, a, h, il};
  endfunction

  task automatic check_out(input string tag);
    out_t got, exp;
    got = {pc_ld, ir_ld, mem_en, mem_wrt, pc_branch, flush,
           reg_out, branch_addr, alu_op, halted, illegal};
    exp = sb.pop_front();
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
    $display("[%0t] %s: outputs %h", $time, tag, got);
  endtask

  task automatic drive_chk(input string tag, input logic h, input logic [15:0] i,
                           input logic [7:0] ra, input out_t e);
    hold = h;
    inst = i;
    regA = ra;
    sb.push_back(e);
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic step(input string tag, input logic h, input logic [15:0] i,
                      input logic [7:0] ra, input out_t e);
    @(posedge clk);
    #1;
    drive_chk(tag, h, i, ra, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ops   [3];
    logic [2:0]  alus  [3];
    logic [15:0] w;
    ops  = '{4'h3, 4'h4, 4'h5};
    alus = '{3'b010, 3'b011, 3'b100};

    // 1: reset, IDLE, ADD r3
    inst = 16'h1321;
    #2;
    sb.push_back(mk(S_NONE, 0, 0, 0, 0, 0));
    check_out("reset_zero");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    drive_chk("idle",     0, 16'h1321, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("add_fetch",     0, 16'h1321, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("add_decode",    0, 16'h1321, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("add_exec",      0, 16'h1321, 8'h00, mk(S_NONE, 0, 0, 3'b000, 0, 0));
    step("add_wb",        0, 16'h1321, 8'h00, mk(S_WB, 4'd3, 0, 3'b000, 0, 0));

    // 2: LDI r5
    step("ldi_fetch",     0, 16'hC5A7, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("ldi_decode",    0, 16'hC5A7, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("ldi_exec",      0, 16'hC5A7, 8'h00, mk(S_NONE, 0, 0, 3'b000, 0, 0));
    step("ldi_wb",        0, 16'hC5A7, 8'h00, mk(S_WB, 4'd5, 0, 3'b000, 0, 0));

    // 3: BZ taken then not taken, JMP
    step("bz0_fetch",     0, 16'h9400, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("bz0_decode",    0, 16'h9400, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("bz0_exec",      0, 16'h9400, 8'h00, mk(S_BR, 0, 8'h40, 0, 0, 0));
    step("bz1_fetch",     0, 16'h9400, 8'h01, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("bz1_decode",    0, 16'h9400, 8'h01, mk(S_NONE, 0, 0, 0, 0, 0));
    step("bz1_exec",      0, 16'h9400, 8'h01, mk(S_NONE, 0, 8'h40, 0, 0, 0));
    step("jmp_fetch",     0, 16'h8AB0, 8'h07, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("jmp_decode",    0, 16'h8AB0, 8'h07, mk(S_NONE, 0, 0, 0, 0, 0));
    step("jmp_exec",      0, 16'h8AB0, 8'h07, mk(S_BR, 0, 8'hAB, 0, 0, 0));

    // AND / OR / XOR to distinct registers
    for (int k = 0; k < 3; k++) begin
      w = {ops[k], 4'(k + 6), 8'h00};
      step("alu_fetch",   0, w, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
      step("alu_decode",  0, w, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
      step("alu_exec",    0, w, 8'h00, mk(S_NONE, 0, 0, alus[k], 0, 0));
      step("alu_wb",      0, w, 8'h00, mk(S_WB, 4'(k + 6), 0, alus[k], 0, 0));
    end

    // 4: SUB r2 with hold across WB
    step("sub_fetch",     0, 16'h2210, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("sub_decode",    0, 16'h2210, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("sub_exec",      0, 16'h2210, 8'h00, mk(S_NONE, 0, 0, 3'b001, 0, 0));
    for (int k = 0; k < 3; k++)
      step("sub_wb_held", 1, 16'h2210, 8'h00, mk(S_WBH, 4'd2, 0, 3'b001, 0, 0));
    step("sub_wb_fire",   0, 16'h2210, 8'h00, mk(S_WB, 4'd2, 0, 3'b001, 0, 0));

    // 5: illegal opcode, briefly held in DECODE
    step("ill_fetch",     0, 16'h6000, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("ill_dec_held",  1, 16'h6000, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("ill_decode",    0, 16'h6000, 8'h00, mk(S_NONE, 0, 0, 0, 0, 1));

    // 6: HLT, long halt with noisy inputs, then async reset
    step("hlt_fetch",     0, 16'hF000, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));
    step("hlt_decode",    0, 16'hF000, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    for (int k = 0; k < 22; k++)
      step("halt", 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
           mk(S_NONE, 0, 0, 0, 1, 0));
    @(posedge clk);
    #2;
    hold = 1'b0;
    inst = 16'h1321;
    rst  = 1'b0;
    sb.push_back(mk(S_NONE, 0, 0, 0, 0, 0));
    #1;
    check_out("rst_async");
    step("rst_held",      0, 16'h1321, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    drive_chk("idle2",    0, 16'h1321, 8'h00, mk(S_NONE, 0, 0, 0, 0, 0));
    step("fetch2",        0, 16'h1321, 8'h00, mk(S_FETCH, 0, 0, 0, 0, 0));

    n_chk++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
